pong_collide: RTL and testbench

Frame-level collision and scoring stage for the Pong display path. Sits directly upstream of the ball mover. Watches the per-pixel ball, paddle and playfield-edge overlaps during active video and classifies each frame's contacts (wall, left/right paddle, left/right goal). Publishes one stable `collision` flag plus class flags before the ball mover samples them on the falling edge of `vsync`, and keeps both players' scores.

---
 rtl/pong_collide.sv | 140 ++++++++++++++
 tb/tb_pong_collide.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pong_collide.sv
// Frame-level collision classifier and score keeper for the Pong display path.
// Optional paddle-hit holdoff is built when PONG_COLLIDE_HOLDOFF_EN is defined.
module pong_collide #(
    parameter int H_ACTIVE       = 640,
    parameter int V_ACTIVE       = 480,
    parameter int TOP_Y          = 8,
    parameter int BOT_Y          = 472,
    parameter int GOAL_L         = 8,
    parameter int GOAL_R         = 632,
    parameter int WIN_SCORE      = 9,
    parameter int HOLDOFF_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       vsync,
    input  logic       ball_px,
    input  logic       lpad_px,
    input  logic       rpad_px,
    output logic       collision,
    output logic       hit_wall,
    output logic       hit_lpad,
    output logic       hit_rpad,
    output logic       goal_l,
    output logic       goal_r,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over
);

    localparam logic [9:0] HA  = 10'(H_ACTIVE);
    localparam logic [9:0] VA  = 10'(V_ACTIVE);
    localparam logic [9:0] TY  = 10'(TOP_Y);
    localparam logic [9:0] BY  = 10'(BOT_Y);
    localparam logic [9:0] GL  = 10'(GOAL_L);
    localparam logic [9:0] GR  = 10'(GOAL_R);
    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    // flag vector layout: [4] wall, [3] lpad, [2] rpad, [1] goal_l, [0] goal_r
    logic [9:0] hc_q, vc_q;
    logic       vsync_q;
    logic [4:0] sticky_q, sticky_d;
    logic [4:0] flags_q, flags_d;
    logic [4:0] pub;
    logic       coll_q, coll_d;
    logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic       go_q, go_d;
    logic       qual, publish, rise_l, rise_r;
    logic       unused_vsync;

    assign unused_vsync = vsync_q;
    assign qual    = (hc_q < HA) && (vc_q < VA);
    assign publish = (vc_q == VA) && (hc_q == '0);

`ifdef PONG_COLLIDE_HOLDOFF_EN
    logic [3:0] hold_q, hold_d;

    always_comb begin
        pub    = sticky_q;
        hold_d = hold_q;
        if (hold_q != '0)
            pub[3:2] = 2'b00;
        if (publish) begin
            if (hold_q != '0)
                hold_d = hold_q - 4'd1;
            else if (pub[3] || pub[2])
                hold_d = 4'(HOLDOFF_FRAMES);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hold_q <= '0;
        else          hold_q <= hold_d;
    end
`else
    localparam int unused_holdoff = HOLDOFF_FRAMES;

    always_comb pub = sticky_q;
`endif

    always_comb begin
        sticky_d = sticky_q;
        if (publish)
            sticky_d = '0;
        else if (qual && ball_px)
            sticky_d = sticky_q | {(vc_q < TY) || (vc_q >= BY), lpad_px, rpad_px,
                                   hc_q < GL, hc_q >= GR};

        flags_d = publish ? pub : flags_q;
        coll_d  = publish ? (|pub) : coll_q;

        // previous-publish copy is the registered flag itself; a held goal scores once
        rise_r = pub[0] & ~flags_q[0];
        rise_l = pub[1] & ~flags_q[1];

        score_l_d = score_l_q;
        score_r_d = score_r_q;
        if (publish && !go_q) begin
            if (rise_r) score_l_d = score_l_q + 4'd1;
            if (rise_l) score_r_d = score_r_q + 4'd1;
        end
        go_d = go_q || (score_l_d == WIN) || (score_r_d == WIN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_q      <= '0;
            vc_q      <= '0;
            vsync_q   <= 1'b0;
            sticky_q  <= '0;
            flags_q   <= '0;
            coll_q    <= 1'b0;
            score_l_q <= '0;
            score_r_q <= '0;
            go_q      <= 1'b0;
        end else begin
            hc_q      <= hcount;
            vc_q      <= vcount;
            vsync_q   <= vsync;
            sticky_q  <= sticky_d;
            flags_q   <= flags_d;
            coll_q    <= coll_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            go_q      <= go_d;
        end
    end

    assign collision = coll_q;
    assign hit_wall  = flags_q[4];
    assign hit_lpad  = flags_q[3];
    assign hit_rpad  = flags_q[2];
    assign goal_l    = flags_q[1];
    assign goal_r    = flags_q[0];
    assign score_l   = score_l_q;
    assign score_r   = score_r_q;
    assign game_over = go_q;

endmodule

// File: tb/tb_pong_collide.sv
// Directed bench for pong_collide on a shrunken raster (32x16 active, 40x20 total).
module tb_pong_collide;

    localparam int HA = 32, VA = 16, HT = 40, VT = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] hcount = '0, vcount = '0;
    logic       vsync;
    logic       ball_px = 1'b0, lpad_px = 1'b0, rpad_px = 1'b0;
    logic       collision, hit_wall, hit_lpad, hit_rpad, goal_l, goal_r, game_over;
    logic [3:0] score_l, score_r;

    logic [9:0] tgt_x = '0, tgt_y = '0;
    logic       tgt_en = 1'b0, lp_en = 1'b0, rp_en = 1'b0;

    int n_chk = 0, n_pass = 0;

    pong_collide #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .TOP_Y(2), .BOT_Y(14),
        .GOAL_L(4), .GOAL_R(28), .WIN_SCORE(9), .HOLDOFF_FRAMES(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .vsync(vsync), .ball_px(ball_px), .lpad_px(lpad_px), .rpad_px(rpad_px),
        .collision(collision), .hit_wall(hit_wall), .hit_lpad(hit_lpad),
        .hit_rpad(hit_rpad), .goal_l(goal_l), .goal_r(goal_r),
        .score_l(score_l), .score_r(score_r), .game_over(game_over)
    );

    always #5 clk = ~clk;

    assign vsync = !((vcount == 10'(VA + 2)) || (vcount == 10'(VA + 3)));

    always @(posedge clk) begin
        if (hcount == 10'(HT - 1)) begin
            hcount <= '0;
            vcount <= (vcount == 10'(VT - 1)) ? '0 : vcount + 10'd1;
        end else begin
            hcount <= hcount + 10'd1;
        end
    end

    // pixel sources lag the raster by one clock, like the real sprite renderer
    always @(posedge clk) begin
        ball_px <= tgt_en && (hcount == tgt_x) && (vcount == tgt_y);
        lpad_px <= tgt_en && lp_en && (hcount == tgt_x) && (vcount == tgt_y);
        rpad_px <= tgt_en && rp_en && (hcount == tgt_x) && (vcount == tgt_y);
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic c, input logic w, input logic lp,
                           input logic rp, input logic gl, input logic gr,
                           input logic [3:0] sl, input logic [3:0] sr, input logic go);
        chk({tag, ".collision"}, 8'(collision), 8'(c));
        chk({tag, ".hit_wall"},  8'(hit_wall),  8'(w));
        chk({tag, ".hit_lpad"},  8'(hit_lpad),  8'(lp));
        chk({tag, ".hit_rpad"},  8'(hit_rpad),  8'(rp));
        chk({tag, ".goal_l"},    8'(goal_l),    8'(gl));
        chk({tag, ".goal_r"},    8'(goal_r),    8'(gr));
        chk({tag, ".score_l"},   8'(score_l),   8'(sl));
        chk({tag, ".score_r"},   8'(score_r),   8'(sr));
        chk({tag, ".game_over"}, 8'(game_over), 8'(go));
    endtask

    // returns #1 after the clock edge on which the DUT publishes
    task automatic wait_publish(input string tag);
        int  n;
        logic seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 2 * HT * VT) begin
            @(posedge clk); #1;
            n++;
            seen = (hcount == '0) && (vcount == 10'(VA));
        end
        chk({tag, ".pub_seen"}, 8'(seen), 8'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic set_tgt(input int x, input int y, input logic en, input logic lp, input logic rp);
        tgt_x  = 10'(x);
        tgt_y  = 10'(y);
        tgt_en = en;
        lp_en  = lp;
        rp_en  = rp;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        logic exp_lp;
        int   n;

        repeat (3) @(negedge clk);
        chk_out("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        wait_publish("first");
        chk_out("first", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        set_tgt(16, 1, 1, 0, 0);
        wait_publish("wall");
        chk_out("wall", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        set_tgt(0, 0, 0, 0, 0);
        wait_publish("empty1");
        chk_out("empty1", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset while the ball is lit in the top wall, with live flags on the outputs
        set_tgt(16, 1, 1, 0, 0);
        wait_publish("prerst");
        chk("prerst.hit_wall", 8'(hit_wall), 8'd1);
        n = 0;
        while (ball_px !== 1'b1 && n < 2 * HT * VT) begin
            @(posedge clk); #1;
            n++;
        end
        chk("midrst.ball_lit", 8'(ball_px), 8'd1);
        reset_n = 1'b0;
        set_tgt(0, 0, 0, 0, 0);
        #1;
        chk_out("midrst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_publish("postrst");
        chk_out("postrst", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        set_tgt(8, 8, 1, 1, 0);
        for (int f = 0; f < 5; f++) begin
`ifdef PONG_COLLIDE_HOLDOFF_EN
            exp_lp = (f == 0);
`else
            exp_lp = 1'b1;
`endif
            wait_publish($sformatf("lpad%0d", f));
            chk_out($sformatf("lpad%0d", f), exp_lp, 0, exp_lp, 0, 0, 0, 0, 0, 0);
        end
        set_tgt(0, 0, 0, 0, 0);
        wait_publish("empty2");
        chk_out("empty2", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        set_tgt(24, 8, 1, 0, 1);
        wait_publish("rpad");
        chk_out("rpad", 1, 0, 0, 1, 0, 0, 0, 0, 0);

        // a stopped ball in the right goal scores once, and goals ignore paddle holdoff
        set_tgt(30, 8, 1, 0, 0);
        for (int f = 0; f < 3; f++) begin
            wait_publish($sformatf("held%0d", f));
            chk_out($sformatf("held%0d", f), 1, 0, 0, 0, 0, 1, 1, 0, 0);
        end
        set_tgt(0, 0, 0, 0, 0);
        wait_publish("empty3");
        chk_out("empty3", 0, 0, 0, 0, 0, 0, 1, 0, 0);

        for (int g = 2; g <= 10; g++) begin
            set_tgt(30, 8, 1, 0, 0);
            wait_publish($sformatf("goal%0d", g));
            chk_out($sformatf("goal%0d", g), 1, 0, 0, 0, 0, 1,
                    4'((g > 9) ? 9 : g), 0, (g >= 9));
            set_tgt(0, 0, 0, 0, 0);
            wait_publish($sformatf("gap%0d", g));
            chk($sformatf("gap%0d.goal_r", g), 8'(goal_r), 8'd0);
        end

        pulse_reset();
        chk_out("rst2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_tgt(1, 1, 1, 0, 0);
        wait_publish("corner");
        chk_out("corner", 1, 1, 0, 0, 1, 0, 0, 1, 0);
        set_tgt(0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
